ps2_kbd_tx: RTL and testbench
=============================

Name: ps2_kbd_tx

Overview:
- Device-side PS/2 transmitter: the keyboard end of the PS/2 link the top level receives on ps2_clk/ps2_data.
- Accepts scan-code bytes through a valid/ready handshake and buffers them in a small FIFO.
- Serializes each byte into an 11-bit PS/2 frame, generating both the PS/2 clock and data.
- Used as a keyboard model in simulation and to drive the PS/2 receiver on-board without a physical keyboard.

Parameters:
- HALF, 25, system clock cycles per PS/2 clock half-period (>=2).
- GAP, 100, minimum idle cycles between the stop bit's end and the next start bit (>=1).
- DEPTH, 8, FIFO depth in bytes (power of 2, >=2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  scan-code byte to send.
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO can accept; equals !full.
- host_inhibit  input  1  host pulling clock low; used only with PS2_INHIBIT_EN.
- ps2_clk  output  1  PS/2 clock, registered, idle high.
- ps2_data  output  1  PS/2 data, registered, idle high.
- busy  output  1  high when a frame is in flight or the FIFO is non-empty.
- byte_count  output  8  frames fully sent, wraps 255->0.

Behaviour:
- Reset: one clock with rst=1 sets ps2_clk=1, ps2_data=1, busy=0, byte_count=0, in_ready=1, FIFO empty and FSM in IDLE. Reset mid-frame truncates the frame immediately with no partial stop bit.
- Handshake: a push happens when in_valid && in_ready. in_ready is low when the FIFO holds DEPTH entries. While full, a pop and an in_valid in the same cycle do not push.
- Frame format: start 0, d0..d7 LSB-first, odd parity, stop 1. The parity bit makes the count of ones over data+parity odd (0x00 gives parity 1).
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, set bit_idx=0, go to HIGH.
  - HIGH: ps2_clk=1 and ps2_data=current bit for HALF cycles, then go to LOW.
  - LOW: ps2_clk=0 for HALF cycles, data held.
    - If bit_idx<10: increment bit_idx and return to HIGH.
    - Else: byte_count++, ps2_data=1, go to GAP.
  - GAP: ps2_clk=1, ps2_data=1 for GAP cycles, then go to IDLE.
- Timing and latency:
  - Data changes only at the start of a HIGH phase, so it is stable HALF cycles before each falling edge of ps2_clk.
  - One frame takes 22*HALF cycles plus GAP.
  - A push into an empty FIFO with the FSM idle makes ps2_data go low 2 cycles after the accepting edge.
- Simultaneous push and pop on a non-full FIFO are both performed, leaving the count unchanged.
- busy deasserts only in IDLE with the FIFO empty.

Optional Feature:
- Macro: PS2_INHIBIT_EN.
- Defined:
  - host_inhibit=1 in IDLE or GAP prevents starting a frame.
  - host_inhibit=1 in HIGH or LOW before bit_idx reaches 10 aborts the frame: ps2_clk=1, ps2_data=1, and the byte is kept for retransmission, not re-queued. The FSM goes to GAP and, once host_inhibit=0, resends the same byte from its start bit.
  - Inhibit during the stop bit (bit_idx=10) is ignored and the frame completes.
  - byte_count counts only completed frames.
- Undefined: host_inhibit is ignored.

Test Plan (HALF=4, GAP=8, DEPTH=8):
- Push 0x1C once -> ps2_data sampled on the 11 ps2_clk falling edges reads 0,0,0,1,1,1,0,0,0,0,1. Start edge occurs 2 cycles after the push. byte_count=1, and busy falls 22*4+8 cycles after the frame starts.
- Push 0xF0, 0x00 and 0xFF back-to-back -> parity bits 1, 1, 1. Each frame is separated by >=8 idle-high cycles. byte_count=3.
- Hold in_valid high for 10 bytes 0x01..0x0A -> the first byte pops at once, 0x02..0x09 fill the FIFO, and in_ready=0 when 0x0A is offered. 0x0A is accepted after the first frame completes. All 10 bytes are sent in order.
- Assert rst during data bit 4 of a frame -> next cycle ps2_clk=1, ps2_data=1, busy=0, byte_count=0, FIFO empty. No further edges occur.
- Send 256 frames -> byte_count wraps to 0.
- With PS2_INHIBIT_EN: assert host_inhibit at bit_idx=5 of 0x1C, release after 20 cycles -> the frame aborts, then 0x1C is resent in full and byte_count=1. Assert host_inhibit at bit_idx=10 -> the frame completes normally.

Source files
------------

// File: rtl/ps2_kbd_tx_if.sv
// Byte-stream handshake into the PS/2 keyboard transmitter.
// The master offers scan codes on in_data/in_valid; the slave answers with in_ready.
interface ps2_kbd_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: device-side PS/2 keyboard transmitter with a scan-code FIFO.
// Host-inhibit handling (abort and resend) is compiled in with `define PS2_INHIBIT_EN.
module ps2_kbd_tx #(
  parameter int HALF  = 25,
  parameter int GAP   = 100,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  ps2_kbd_tx_if.slave  in_bus,
  input  logic         host_inhibit,
  output logic         ps2_clk,
  output logic         ps2_data,
  output logic         busy,
  output logic [7:0]   byte_count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXC = (HALF > GAP) ? HALF : GAP;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
  localparam logic [AW:0]   CNT_EMPTY = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   FIFO_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [3:0]    STOP_IDX  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

  // Bit k of the result is the k-th bit on the wire: start, d0..d7, parity, stop.
  function automatic logic [10:0] build_frame(input logic [7:0] d);
    return {1'b1, odd_parity(d), d, 1'b0};
  endfunction

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic [3:0]    bit_idx_r;
  logic [3:0]    bit_idx_s;
  logic [10:0]   frame_r;
  logic [10:0]   frame_s;
  logic          retry_r;
  logic          retry_s;
  logic          done_s;
  logic          abort_s;
  logic          inhibit_s;

  logic          ps2_clk_r;
  logic          ps2_data_r;
  logic          busy_r;
  logic [7:0]    byte_count_r;

`ifdef PS2_INHIBIT_EN
  assign inhibit_s = host_inhibit;
`else
  logic unused_inhibit_s;
  assign unused_inhibit_s = host_inhibit;
  assign inhibit_s        = 1'b0;
`endif

  assign full_s          = (count_r == CNT_FULL);
  assign empty_s         = (count_r == CNT_EMPTY);
  assign in_bus.in_ready = ~full_s;
  assign push_s          = in_bus.in_valid & ~full_s;
  // The stop bit is never aborted; an inhibit there lets the frame finish.
  assign abort_s         = inhibit_s & (bit_idx_r != STOP_IDX);

  // FIFO storage; contents need no reset because count_r qualifies them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_bus.in_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_EMPTY;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + FIFO_ONE;
        2'b01:   count_r <= count_r - FIFO_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 4'd0;
      frame_r   <= 11'h7FF;
      retry_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_idx_r <= bit_idx_s;
      frame_r   <= frame_s;
      retry_r   <= retry_s;
    end
  end

  // Sequencer next-state: HIGH and LOW phases of HALF cycles per bit, then GAP.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_idx_s = bit_idx_r;
    frame_s   = frame_r;
    retry_s   = retry_r;
    pop_s     = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (inhibit_s) begin
          state_s = ST_IDLE;
        end else if (retry_r) begin
          state_s   = ST_HIGH;
          cnt_s     = CNT_ZERO;
          bit_idx_s = 4'd0;
          retry_s   = 1'b0;
        end else if (!empty_s) begin
          state_s   = ST_HIGH;
          cnt_s     = CNT_ZERO;
          bit_idx_s = 4'd0;
          frame_s   = build_frame(mem_r[rd_ptr_r]);
          pop_s     = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (abort_s) begin
          state_s = ST_GAP;
          cnt_s   = CNT_ZERO;
          retry_s = 1'b1;
        end else if (cnt_r == HALF_LAST) begin
          state_s = ST_LOW;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_LOW: begin
        if (abort_s) begin
          state_s = ST_GAP;
          cnt_s   = CNT_ZERO;
          retry_s = 1'b1;
        end else if (cnt_r == HALF_LAST) begin
          cnt_s = CNT_ZERO;
          if (bit_idx_r < STOP_IDX) begin
            bit_idx_s = bit_idx_r + 4'd1;
            state_s   = ST_HIGH;
          end else begin
            done_s  = 1'b1;
            state_s = ST_GAP;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_r == GAP_LAST) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Registered line outputs follow the sequencer state one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_clk_r    <= 1'b1;
      ps2_data_r   <= 1'b1;
      busy_r       <= 1'b0;
      byte_count_r <= 8'd0;
    end else begin
      ps2_clk_r  <= (state_r != ST_LOW);
      ps2_data_r <= ((state_r == ST_HIGH) || (state_r == ST_LOW)) ? frame_r[bit_idx_r] : 1'b1;
      busy_r     <= (state_r != ST_IDLE) | ~empty_s | retry_r | push_s;
      if (done_s) begin
        byte_count_r <= byte_count_r + 8'd1;
      end
    end
  end

  assign ps2_clk    = ps2_clk_r;
  assign ps2_data   = ps2_data_r;
  assign busy       = busy_r;
  assign byte_count = byte_count_r;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: a line monitor decodes frames off ps2_clk/ps2_data
// and each scenario compares them with frames built from the byte stream it pushed.
module tb_ps2_kbd_tx;
  localparam int HALF      = 4;
  localparam int GAP       = 8;
  localparam int DEPTH     = 8;
  localparam int FRAME_CYC = 22 * HALF + GAP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_inhibit = 1'b0;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [7:0] byte_count;

  ps2_kbd_tx_if bus ();

  ps2_kbd_tx #(.HALF(HALF), .GAP(GAP), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_bus       (bus),
    .host_inhibit (host_inhibit),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .busy         (busy),
    .byte_count   (byte_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] bits;
    int          t_first;
    int          t_last;
  } frame_t;

  frame_t      frames_q[$];
  logic [7:0]  exp_q[$];
  int          exp_count = 0;
  int          cyc = 0;
  int          falls = 0;
  int          aborts = 0;
  int          bits_n = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // Expected wire frame from the byte value: bit k is the k-th bit sent.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b, 1'b0};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Line monitor: samples data on each ps2_clk falling edge, drops frames cut short.
  initial begin
    logic [10:0] cur;
    int          cur_first;
    int          high_run;
    logic        prev_clk;
    cur = 11'd0; cur_first = 0; high_run = 0; prev_clk = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        bits_n   = 0;
        high_run = 0;
      end else begin
        if (ps2_clk === 1'b1) high_run++;
        else high_run = 0;
        if (bits_n != 0 && high_run > HALF + 2) begin
          bits_n = 0;
          aborts++;
        end
        if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
          falls++;
          if (bits_n == 0) cur_first = cyc;
          cur[bits_n] = ps2_data;
          bits_n++;
          if (bits_n == 11) begin
            frames_q.push_back('{bits: cur, t_first: cur_first, t_last: cyc});
            bits_n = 0;
          end
        end
      end
      prev_clk = ps2_clk;
    end
  end

  task automatic push_byte(input logic [7:0] d, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (bus.in_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_checks++;
      $display("FAIL push_timeout byte %02h in_ready=%b, required 1", d, bus.in_ready);
      acc = -1;
    end else begin
      acc = cyc + 1;
      exp_q.push_back(d);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int t);
    int n;
    n = 0;
    while ((busy !== 1'b0 || bits_n != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      n_checks++;
      $display("FAIL idle_timeout busy=%b after %0d cycles, required 0", busy, n);
      t = -1;
    end else begin
      t = cyc;
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (ps2_clk !== 1'b1) $display("FAIL rst_clk got %b required 1", ps2_clk); else n_pass++;
    n_checks++; if (ps2_data !== 1'b1) $display("FAIL rst_data got %b required 1", ps2_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b required 0", busy); else n_pass++;
    n_checks++; if (byte_count !== 8'd0) $display("FAIL rst_count got %0d required 0", byte_count); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_ready got %b required 1", bus.in_ready); else n_pass++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || ps2_clk !== 1'b1) $display("FAIL idle_after_rst busy=%b clk=%b required 0/1", busy, ps2_clk); else n_pass++;
    exp_count = 0;
  endtask

  task automatic test_single();
    int acc, first_low, t_idle, n;
    frame_t fr;
    logic [10:0] spec_bits;
    spec_bits = 11'b10000111000;
    push_byte(8'h1C, acc);
    exp_count++;
    n = 0;
    while (ps2_data !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    first_low = cyc;
    n_checks++; if (first_low - acc != 2) $display("FAIL start_latency got %0d required 2", first_low - acc); else n_pass++;
    wait_idle(500, t_idle);
    n_checks++; if (t_idle - first_low != FRAME_CYC) $display("FAIL busy_fall got %0d required %0d", t_idle - first_low, FRAME_CYC); else n_pass++;
    void'(exp_q.pop_front());
    n_checks++;
    if (frames_q.size() != 1) begin
      $display("FAIL single_frames got %0d frames required 1", frames_q.size());
    end else begin
      fr = frames_q.pop_front();
      if (fr.bits !== spec_bits) $display("FAIL single_bits got %011b required %011b", fr.bits, spec_bits);
      else n_pass++;
      n_checks++; if (fr.t_first - first_low != HALF) $display("FAIL first_fall got %0d required %0d", fr.t_first - first_low, HALF); else n_pass++;
    end
    n_checks++; if (byte_count !== 8'(exp_count)) $display("FAIL single_count got %0d required %0d", byte_count, exp_count); else n_pass++;
    frames_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6];
    logic [7:0] exp_b;
    frame_t     got[$];
    int         acc, t_idle, k;
    bytes[0] = 8'hF0; bytes[1] = 8'h00; bytes[2] = 8'hFF;
    for (int i = 3; i < 6; i++) bytes[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 6; i++) push_byte(bytes[i], acc);
    exp_count += 6;
    wait_idle(2000, t_idle);
    got = frames_q;
    frames_q.delete();
    n_checks++; if (got.size() != 6) $display("FAIL b2b_frames got %0d required 6", got.size()); else n_pass++;
    k = 0;
    while (exp_q.size() != 0) begin
      exp_b = exp_q.pop_front();
      n_checks++;
      if (k >= got.size()) begin
        $display("FAIL b2b_frame missing frame for byte %02h", exp_b);
      end else begin
        if (got[k].bits !== ref_frame(exp_b)) $display("FAIL b2b_frame %0d got %011b required %011b", k, got[k].bits, ref_frame(exp_b));
        else n_pass++;
        if (k < 3) begin
          n_checks++; if (got[k].bits[9] !== 1'b1) $display("FAIL b2b_parity %0d got %b required 1", k, got[k].bits[9]); else n_pass++;
        end
        if (k > 0) begin
          n_checks++;
          if (got[k].t_first - got[k-1].t_last < 2 * HALF + GAP)
            $display("FAIL b2b_gap %0d got %0d required >=%0d", k, got[k].t_first - got[k-1].t_last, 2 * HALF + GAP);
          else n_pass++;
        end
      end
      k++;
    end
    n_checks++; if (byte_count !== 8'(exp_count)) $display("FAIL b2b_count got %0d required %0d", byte_count, exp_count); else n_pass++;
  endtask

  task automatic test_fifo_full();
    int         acc [11];
    int         idx, guard, t_idle;
    logic       ready10;
    logic       seen10;
    logic       took;
    logic [7:0] exp_b;
    frame_t     fr;
    for (int i = 0; i < 11; i++) acc[i] = 0;
    idx = 1; guard = 0; seen10 = 1'b0; ready10 = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'(idx);
    while (idx <= 10 && guard < 3000) begin
      if (idx == 10 && !seen10) begin
        ready10 = bus.in_ready;
        seen10  = 1'b1;
      end
      took = (bus.in_ready === 1'b1);
      if (took) begin
        acc[idx] = cyc + 1;
        exp_q.push_back(8'(idx));
      end
      @(negedge clk);
      guard++;
      if (took) begin
        idx++;
        bus.in_data = 8'(idx);
      end
    end
    bus.in_valid = 1'b0;
    exp_count += 10;
    n_checks++; if (guard >= 3000) $display("FAIL full_timeout accepted %0d bytes, required 10", idx - 1); else n_pass++;
    n_checks++; if (ready10 !== 1'b0) $display("FAIL full_ready10 got %b required 0", ready10); else n_pass++;
    n_checks++; if (acc[9] - acc[1] != 8) $display("FAIL full_fill got %0d required 8", acc[9] - acc[1]); else n_pass++;
    n_checks++; if (acc[10] - acc[1] < FRAME_CYC) $display("FAIL full_accept10 got %0d required >=%0d", acc[10] - acc[1], FRAME_CYC); else n_pass++;
    wait_idle(3000, t_idle);
    while (exp_q.size() != 0) begin
      exp_b = exp_q.pop_front();
      n_checks++;
      if (frames_q.size() == 0) begin
        $display("FAIL full_frame missing frame for byte %02h", exp_b);
      end else begin
        fr = frames_q.pop_front();
        if (fr.bits !== ref_frame(exp_b)) $display("FAIL full_frame got %011b required %011b", fr.bits, ref_frame(exp_b));
        else n_pass++;
      end
    end
    n_checks++; if (frames_q.size() != 0) $display("FAIL full_extra got %0d extra frames required 0", frames_q.size()); else n_pass++;
    n_checks++; if (byte_count !== 8'(exp_count)) $display("FAIL full_count got %0d required %0d", byte_count, exp_count); else n_pass++;
    frames_q.delete();
  endtask

`ifdef PS2_INHIBIT_EN
  task automatic test_inhibit();
    int     acc, n, t_idle, ab0;
    frame_t fr;
    ab0 = aborts;
    push_byte(8'h1C, acc);
    n = 0;
    while (bits_n != 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (HALF + 1) @(negedge clk);
    host_inhibit = 1'b1;
    repeat (20) @(negedge clk);
    host_inhibit = 1'b0;
    wait_idle(1000, t_idle);
    exp_count++;
    n_checks++; if (aborts - ab0 != 1) $display("FAIL inh_abort got %0d aborts required 1", aborts - ab0); else n_pass++;
    n_checks++;
    if (frames_q.size() != 1) $display("FAIL inh_resend got %0d frames required 1", frames_q.size());
    else begin
      fr = frames_q.pop_front();
      if (fr.bits !== ref_frame(8'h1C)) $display("FAIL inh_resend got %011b required %011b", fr.bits, ref_frame(8'h1C));
      else n_pass++;
    end
    n_checks++; if (byte_count !== 8'(exp_count)) $display("FAIL inh_count got %0d required %0d", byte_count, exp_count); else n_pass++;
    void'(exp_q.pop_front());
    push_byte(8'h1C, acc);
    n = 0;
    while (bits_n != 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (HALF + 1) @(negedge clk);
    host_inhibit = 1'b1;
    wait_idle(1000, t_idle);
    host_inhibit = 1'b0;
    exp_count++;
    n_checks++;
    if (frames_q.size() != 1) $display("FAIL inh_stop got %0d frames required 1", frames_q.size());
    else begin
      fr = frames_q.pop_front();
      if (fr.bits !== ref_frame(8'h1C)) $display("FAIL inh_stop got %011b required %011b", fr.bits, ref_frame(8'h1C));
      else n_pass++;
    end
    n_checks++; if (byte_count !== 8'(exp_count)) $display("FAIL inh_stop_count got %0d required %0d", byte_count, exp_count); else n_pass++;
    void'(exp_q.pop_front());
    frames_q.delete();
    repeat (GAP + 4) @(negedge clk);
  endtask
`endif

  task automatic test_reset_midframe();
    int acc, n, f0;
    push_byte(8'($urandom_range(0, 255)), acc);
    push_byte(8'($urandom_range(0, 255)), acc);
    n = 0;
    while (bits_n != 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    n_checks++; if (n >= 500) $display("FAIL mid_wait bits=%0d required 5", bits_n); else n_pass++;
    repeat (HALF + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (ps2_clk !== 1'b1) $display("FAIL mid_rst_clk got %b required 1", ps2_clk); else n_pass++;
    n_checks++; if (ps2_data !== 1'b1) $display("FAIL mid_rst_data got %b required 1", ps2_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b required 0", busy); else n_pass++;
    n_checks++; if (byte_count !== 8'd0) $display("FAIL mid_rst_count got %0d required 0", byte_count); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL mid_rst_ready got %b required 1", bus.in_ready); else n_pass++;
    rst = 1'b0;
    exp_q.delete();
    frames_q.delete();
    exp_count = 0;
    f0 = falls;
    repeat (200) @(negedge clk);
    n_checks++; if (falls != f0) $display("FAIL mid_no_edges got %0d edges required 0", falls - f0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_idle_busy got %b required 0", busy); else n_pass++;
  endtask

  task automatic test_wrap();
    int         acc, t_idle, bad;
    logic [7:0] exp_b;
    frame_t     fr;
    bad = 0;
    for (int i = 0; i < 256; i++) push_byte(8'($urandom_range(0, 255)), acc);
    exp_count += 256;
    wait_idle(3000, t_idle);
    while (exp_q.size() != 0) begin
      exp_b = exp_q.pop_front();
      n_checks++;
      if (frames_q.size() == 0) begin
        if (bad < 5) $display("FAIL wrap_frame missing frame for byte %02h", exp_b);
        bad++;
      end else begin
        fr = frames_q.pop_front();
        if (fr.bits !== ref_frame(exp_b)) begin
          if (bad < 5) $display("FAIL wrap_frame got %011b required %011b", fr.bits, ref_frame(exp_b));
          bad++;
        end else n_pass++;
      end
    end
    n_checks++; if (byte_count !== 8'(exp_count)) $display("FAIL wrap_count got %0d required %0d", byte_count, 8'(exp_count)); else n_pass++;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
`ifdef PS2_INHIBIT_EN
    test_inhibit();
`endif
    test_reset_midframe();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
